// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the data-memory responder: FSM state
//               encoding, default geometry constants and an index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dmem_state_t;

   // Default geometry
   localparam int DMEM_DATA_WIDTH = 8;
   localparam int DMEM_ADDR_WIDTH = 8;
   localparam int DMEM_DEPTH      = 16;
   localparam int DMEM_LATENCY    = 2;

   // Countdown width; large enough for the maximum latency of 15
   localparam int DMEM_CNT_W      = 4;

   // Array index width; never below one bit so degenerate depths still elaborate
   function automatic int dmem_idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Word storage for the data-memory responder. Synchronous write,
//               combinational read, synchronous clear of every word on rst.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
   parameter int DEPTH      = DMEM_DEPTH,
   parameter int IDX_W      = dmem_idx_w(DMEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [IDX_W-1:0]      raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Clear all words on reset, otherwise write one word when enabled
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Fixed-latency data-memory responder for the MEM stage. Accepts
//               one request at a time in IDLE, counts down LATENCY cycles and
//               emits a one-cycle resp_valid pulse. Stores commit only on the
//               edge that ends the response cycle, so an abandoned request
//               (reset mid-flight) never touches the array.
//               Optional build macro DMEM_ADDR_CHECK_EN: out-of-range
//               addresses are flagged on resp_err instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
   parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
   parameter int DATA_DEPTH = DMEM_DEPTH,
   parameter int LATENCY    = DMEM_LATENCY
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  stall
`ifdef DMEM_ADDR_CHECK_EN
   ,
   output logic                  resp_err
`endif
);

   localparam int IDX_W = dmem_idx_w(DATA_DEPTH);
   localparam int CNT_W = DMEM_CNT_W;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   dmem_state_t           state;
   logic [CNT_W-1:0]      cnt;
   logic                  wr_q;
   logic [IDX_W-1:0]      idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  err_q;

   logic                  accept;
   logic                  addr_err;
   logic                  mem_we;
   logic [IDX_W-1:0]      rd_idx;
   logic [DATA_WIDTH-1:0] rd_data;

`ifdef DMEM_ADDR_CHECK_EN
   logic                  err_r;

   // Any address beyond the array is an error rather than an alias
   assign addr_err = ({1'b0, req_addr} >= (ADDR_WIDTH + 1)'(DATA_DEPTH));
   assign resp_err = err_r;
`else
   // Upper address bits are discarded by the modulo indexing
   logic                  unused_addr_bits;

   assign addr_err         = 1'b0;
   assign unused_addr_bits = ^req_addr;
`endif

   assign accept = (state == ST_IDLE) && req_valid;
   assign stall  = accept || (state == ST_WAIT);

   // In IDLE the read port looks at the live request (needed when LATENCY=1);
   // afterwards it looks at the latched index.
   assign rd_idx = (state == ST_IDLE) ? req_addr[IDX_W-1:0] : idx_q;

   // Store commits on the edge that closes the RESP cycle
   assign mem_we = (state == ST_RESP) && wr_q && !err_q;

   dmem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DATA_DEPTH),
      .IDX_W      (IDX_W)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .waddr (idx_q),
      .wdata (wdata_q),
      .raddr (rd_idx),
      .rdata (rd_data)
   );

   // Request FSM with registered handshake and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         wr_q       <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
`ifdef DMEM_ADDR_CHECK_EN
         err_r      <= 1'b0;
`endif
      end else begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
`ifdef DMEM_ADDR_CHECK_EN
         err_r      <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  wr_q      <= req_write;
                  idx_q     <= req_addr[IDX_W-1:0];
                  wdata_q   <= req_wdata;
                  err_q     <= addr_err;
                  cnt       <= CNT_LOAD;
                  req_ready <= 1'b0;
                  if (LATENCY == 1) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= (req_write || addr_err) ? '0 : rd_data;
`ifdef DMEM_ADDR_CHECK_EN
                     err_r      <= addr_err;
`endif
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == CNT_ONE) begin
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= (wr_q || err_q) ? '0 : rd_data;
`ifdef DMEM_ADDR_CHECK_EN
                  err_r      <= err_q;
`endif
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            ST_RESP: begin
               state     <= ST_IDLE;
               cnt       <= '0;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               cnt       <= '0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder. One instance
//               uses LATENCY=2 (default), a second uses LATENCY=1.
//               Honours DMEM_ADDR_CHECK_EN for the out-of-range case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   // LATENCY=2 instance
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   logic [7:0] req_addr  = 8'h00;
   logic [7:0] req_wdata = 8'h00;
   logic       req_ready;
   logic       resp_valid;
   logic [7:0] resp_rdata;
   logic       stall;
   logic       resp_err;

   // LATENCY=1 instance
   logic       v1 = 1'b0;
   logic       w1 = 1'b0;
   logic [7:0] a1 = 8'h00;
   logic [7:0] d1 = 8'h00;
   logic       ready1;
   logic       rvalid1;
   logic [7:0] rdata1;
   logic       stall1;
   logic       err1;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DATA_DEPTH(16), .LATENCY(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .stall      (stall)
`ifdef DMEM_ADDR_CHECK_EN
      ,
      .resp_err   (resp_err)
`endif
   );

   dmem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DATA_DEPTH(16), .LATENCY(1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (v1),
      .req_write  (w1),
      .req_addr   (a1),
      .req_wdata  (d1),
      .req_ready  (ready1),
      .resp_valid (rvalid1),
      .resp_rdata (rdata1),
      .stall      (stall1)
`ifdef DMEM_ADDR_CHECK_EN
      ,
      .resp_err   (err1)
`endif
   );

`ifndef DMEM_ADDR_CHECK_EN
   assign resp_err = 1'b0;
   assign err1     = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // One request on the selected instance. Starts 1 time unit after an edge
   // with the DUT idle; returns the data, error flag, cycles from accept to
   // resp_valid and number of stalled cycles. Ends 1 unit after the edge
   // that closes the response cycle.
   task automatic xact(input bit u1, input logic wr, input logic [7:0] addr,
                       input logic [7:0] wd, output logic [7:0] rd,
                       output logic er, output int lat, output int stc);
      bit seen = 1'b0;
      rd  = 8'h00;
      er  = 1'b0;
      lat = -1;
      stc = 0;
      if (u1) begin
         v1 = 1'b1; w1 = wr; a1 = addr; d1 = wd;
      end else begin
         req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
      end
      for (int k = 0; k < 20 && !seen; k++) begin
         #2;
         if (u1 ? stall1 : stall) stc++;
         if (u1 ? rvalid1 : resp_valid) begin
            seen = 1'b1;
            lat  = k;
            rd   = u1 ? rdata1 : resp_rdata;
            er   = u1 ? err1 : resp_err;
         end
         @(posedge clk);
         #1;
         if (k == 0) begin
            v1        = 1'b0;
            req_valid = 1'b0;
         end
      end
      if (!seen) check("xact_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd;
      logic       er;
      int         lat;
      int         stc;
      int         pulses;
      int         nacc;
      int         cyc;
      int         acc_cyc [3];
      bit         accepted;
      bit         drained;

      // ---------------- reset state
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #2;
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_stall", stall, 0);
      check("rst_ready_lat1", ready1, 1);
      @(posedge clk);
      #1;

      // ---------------- store/load, LATENCY=2
      xact(0, 1'b1, 8'h05, 8'hA5, rd, er, lat, stc);
      check("st5_latency", lat, 2);
      check("st5_stall_cycles", stc, 2);
      check("st5_rdata_zero", rd, 0);
      xact(0, 1'b0, 8'h05, 8'h00, rd, er, lat, stc);
      check("ld5_rdata", rd, 8'hA5);
      check("ld5_latency", lat, 2);
      check("ld5_stall_cycles", stc, 2);
      #2;
      check("idle_rdata_zero", resp_rdata, 0);
      check("idle_stall", stall, 0);
      check("idle_ready", req_ready, 1);
      @(posedge clk);
      #1;

      // ---------------- LATENCY=1 instance
      xact(1, 1'b0, 8'h00, 8'h00, rd, er, lat, stc);
      check("l1_ld0_latency", lat, 1);
      check("l1_ld0_rdata", rd, 0);
      check("l1_ld0_stall", stc, 1);
      xact(1, 1'b1, 8'h02, 8'h5A, rd, er, lat, stc);
      check("l1_st2_latency", lat, 1);
      xact(1, 1'b0, 8'h02, 8'h00, rd, er, lat, stc);
      check("l1_ld2_rdata", rd, 8'h5A);

      // ---------------- reset mid-WAIT abandons the store
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h03; req_wdata = 8'h77;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst       = 1'b1;
      pulses    = 0;
      repeat (2) begin
         #2;
         if (resp_valid) pulses++;
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      repeat (5) begin
         #2;
         if (resp_valid) pulses++;
         @(posedge clk);
         #1;
      end
      check("rstmid_resp_pulses", pulses, 0);
      check("rstmid_req_ready", req_ready, 1);
      xact(0, 1'b0, 8'h03, 8'h00, rd, er, lat, stc);
      check("rstmid_ld3_rdata", rd, 0);
      xact(0, 1'b0, 8'h05, 8'h00, rd, er, lat, stc);
      check("rstmid_ld5_cleared", rd, 0);

      // ---------------- address wrap / range check
      xact(0, 1'b1, 8'h13, 8'h3C, rd, er, lat, stc);
`ifdef DMEM_ADDR_CHECK_EN
      check("wrap_st_err", er, 1);
      xact(0, 1'b0, 8'h03, 8'h00, rd, er, lat, stc);
      check("wrap_ld3_rdata", rd, 0);
      check("wrap_ld3_err", er, 0);
`else
      check("wrap_st_rdata", rd, 0);
      xact(0, 1'b0, 8'h03, 8'h00, rd, er, lat, stc);
      check("wrap_ld3_rdata", rd, 8'h3C);
`endif

      // ---------------- busy: changed request during WAIT is ignored
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h07; req_wdata = 8'h11;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         #2;
         if (resp_valid) pulses++;
         @(posedge clk);
         #1;
         if (k == 0) begin
            req_addr  = 8'h09;
            req_wdata = 8'h22;
         end
         if (k == 1) req_valid = 1'b0;
      end
      check("busy_resp_pulses", pulses, 1);
      xact(0, 1'b0, 8'h07, 8'h00, rd, er, lat, stc);
      check("busy_ld7_rdata", rd, 8'h11);
      xact(0, 1'b0, 8'h09, 8'h00, rd, er, lat, stc);
      check("busy_ld9_rdata", rd, 0);

      // ---------------- back-to-back stores with req_valid held
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h0A; req_wdata = 8'hB1;
      nacc = 0;
      cyc  = 0;
      while (nacc < 3 && cyc < 30) begin
         #2;
         accepted = req_ready;
         if (accepted) begin
            acc_cyc[nacc] = cyc;
            nacc++;
         end
         @(posedge clk);
         #1;
         if (accepted) begin
            if (nacc == 3) begin
               req_valid = 1'b0;
            end else begin
               req_addr  = 8'h0A + 8'(nacc);
               req_wdata = 8'hB1 + 8'(nacc);
            end
         end
         cyc++;
      end
      req_valid = 1'b0;
      check("b2b_accepts", nacc, 3);
      if (nacc == 3) begin
         check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 3);
         check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 3);
      end
      drained = 1'b0;
      for (int i = 0; i < 10 && !drained; i++) begin
         #2;
         if (req_ready) drained = 1'b1;
         @(posedge clk);
         #1;
      end
      check("b2b_drain", drained, 1);
      xact(0, 1'b0, 8'h0A, 8'h00, rd, er, lat, stc);
      check("b2b_ld10", rd, 8'hB1);
      xact(0, 1'b0, 8'h0B, 8'h00, rd, er, lat, stc);
      check("b2b_ld11", rd, 8'hB2);
      xact(0, 1'b0, 8'h0C, 8'h00, rd, er, lat, stc);
      check("b2b_ld12", rd, 8'hB3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: request address width.
REQ-003 SHALL have parameter DATA_DEPTH, default 16: number of stored words, power of two.
REQ-004 SHALL have parameter LATENCY, default 2: accept-to-response cycles, legal range 1..15.
REQ-005 SHALL have port clk  input  1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  1: MEM stage presents a request.
REQ-008 SHALL have port req_write  input  1: 1 = store, 0 = load.
REQ-009 SHALL have port req_addr  input  ADDR_WIDTH: word address (EXMEM ALU result).
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH: store data.
REQ-011 SHALL have port req_ready  output  1: responder can accept a request this cycle.
REQ-012 SHALL have port resp_valid  output  1: one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata  output  DATA_WIDTH: load data, valid only with resp_valid.
REQ-014 SHALL have port stall  output  1: pipeline freeze request to the core.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready.
REQ-017 SHALL on accept latch write, addr, wdata and load the countdown counter with LATENCY-1.
REQ-018 SHALL go IDLE->RESP directly when LATENCY=1, else IDLE->WAIT.
REQ-019 SHALL in WAIT decrement the counter each cycle and move to RESP when it reaches 1.
REQ-020 SHALL in RESP assert resp_valid for exactly one cycle, then return to IDLE.
REQ-021 SHALL commit a store to the array on the RESP cycle edge, never earlier.
REQ-022 SHALL drive resp_rdata with the addressed word for loads; 0 for stores.
REQ-023 SHALL hold resp_rdata at 0 whenever resp_valid is 0.
REQ-024 SHALL index the array with req_addr modulo DATA_DEPTH (low log2(DATA_DEPTH) bits).
REQ-025 SHALL drive stall = 1 in the accept cycle (IDLE with req_valid) and in WAIT; 0 in RESP and idle IDLE.
REQ-026 SHALL ignore req_* inputs outside IDLE; no queuing, no second outstanding request.
REQ-027 SHALL accept a new request in the IDLE cycle immediately following RESP (back-to-back throughput LATENCY+1 cycles).
REQ-028 SHALL give a load following a store to the same address the newly stored value.

Reset
REQ-029 SHALL on rst return to IDLE, clear counter, drive req_ready=1 (after reset), resp_valid=0, resp_rdata=0, stall=0.
REQ-030 SHALL clear all array words to 0 on rst.
REQ-031 SHALL abandon any in-flight request on rst with no store committed and no resp_valid.

Configuration
REQ-032 SHALL with DMEM_ADDR_CHECK_EN defined treat req_addr >= DATA_DEPTH as an error: no store commit, resp_rdata=0, plus extra output resp_err (1 bit) asserted with resp_valid.
REQ-033 SHALL without DMEM_ADDR_CHECK_EN apply modulo wrap per REQ-024 and have no resp_err port.

Structure
REQ-034 SHALL take FSM state encoding and default width constants from shared package mips_pkg.
REQ-035 SHALL place storage in sub-module dmem_array (sync write, combinational read, sync clear).

Verification
REQ-036 Reset: rst for 2 cycles mid-WAIT of a store to addr 3 -> resp_valid never pulses, later load addr 3 returns 0x00.
REQ-037 Store/load, LATENCY=2: store 0xA5 to addr 5 -> resp_valid at accept+2, stall high 2 cycles; load addr 5 -> resp_rdata=0xA5.
REQ-038 LATENCY=1: load addr 0 after reset -> resp_valid in next cycle, resp_rdata=0x00, stall high 1 cycle.
REQ-039 Wrap: store 0x3C to addr 0x13 (DATA_DEPTH=16) -> load addr 0x03 returns 0x3C; with DMEM_ADDR_CHECK_EN, resp_err=1 and load addr 0x03 returns 0x00.
REQ-040 Busy ignore: req_valid held with changing addr during WAIT -> only first request served, one resp_valid pulse.
REQ-041 Back-to-back: continuous req_valid for 3 stores -> accepts spaced LATENCY+1 cycles, all three values readable.
